// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall/flush control and saturating perf counters
module pipe_stage_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                STALL_W   = 6,
    parameter int                STAGE     = 2,
    parameter int                CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic               err
);

    generate
        if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
        end
    endgenerate

    logic              up;
    logic              dn;
    logic              unused_stall;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              err_q, err_d;
    logic              stall_inc, bubble_inc, flush_inc;

    assign up           = stall[STAGE];
    assign dn           = stall[STAGE+1];
    assign unused_stall = ^stall;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic clr, input logic inc);
        if (clr)
            return '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            return cnt + CNT_W'(1);
        else
            return cnt;
    endfunction

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        err_d      = err_q;
        stall_inc  = 1'b0;
        bubble_inc = 1'b0;
        flush_inc  = 1'b0;
        if (flush) begin
            valid_d   = 1'b0;
            data_d    = NOP_VALUE;
            flush_inc = 1'b1;
        end else if (up && !dn) begin
            valid_d    = 1'b0;
            data_d     = NOP_VALUE;
            bubble_inc = 1'b1;
        end else if (dn) begin
            // Downstream stalled: hold; a running upstream here would lose data, so flag it.
            stall_inc = 1'b1;
            if (!up)
                err_d = 1'b1;
        end else begin
            valid_d = in_valid;
            data_d  = in_data;
        end
        stall_cnt_d  = cnt_next(stall_cnt_q,  cnt_clr, stall_inc);
        bubble_cnt_d = cnt_next(bubble_cnt_q, cnt_clr, bubble_inc);
        flush_cnt_d  = cnt_next(flush_cnt_q,  cnt_clr, flush_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            data_q       <= NOP_VALUE;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            err_q        <= err_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg (STAGE=2, CNT_W=4, non-zero NOP)
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [5:0]  RUN  = 6'b000000;
    localparam logic [5:0]  BUB  = 6'b000100;
    localparam logic [5:0]  HOLD = 6'b001100;
    localparam logic [5:0]  ILL  = 6'b001000;
    localparam logic [5:0]  IGN  = 6'b110011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  stall_cnt, bubble_cnt, flush_cnt;
    logic        err;

    pipe_stage_reg #(
        .DATA_W(32), .NOP_VALUE(NOP), .STALL_W(6), .STAGE(2), .CNT_W(4)
    ) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        v;
        logic [31:0] d;
        logic [3:0]  s, b, f;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   vid   = 0;

    function automatic void compare(input exp_t x);
        n_vec++;
        if (out_valid !== x.v || out_data !== x.d || stall_cnt !== x.s ||
            bubble_cnt !== x.b || flush_cnt !== x.f || err !== x.e) begin
            n_err++;
            $display("FAIL vec%0d: got v=%b d=%h s=%0d b=%0d f=%0d e=%b, want v=%b d=%h s=%0d b=%0d f=%0d e=%b",
                     x.id, out_valid, out_data, stall_cnt, bubble_cnt, flush_cnt, err,
                     x.v, x.d, x.s, x.b, x.f, x.e);
        end
    endfunction

    function automatic exp_t mk(input logic v, input logic [31:0] d, input int s, input int b,
                                input int f, input logic e);
        exp_t x;
        x.id = vid; x.v = v; x.d = d;
        x.s = 4'(s); x.b = 4'(b); x.f = 4'(f); x.e = e;
        return x;
    endfunction

    // Monitor: one expectation per clock, checked at the falling edge after it was queued.
    always @(negedge clk) begin
        if (sb.size() > 0 && !rst)
            compare(sb.pop_front());
    end

    task automatic vec(input logic [5:0] st, input logic fl, input logic cl, input logic iv,
                       input logic [31:0] id, input logic ev, input logic [31:0] ed,
                       input int es, input int eb, input int ef, input logic ee);
        stall = st; flush = fl; cnt_clr = cl; in_valid = iv; in_data = id;
        @(posedge clk);
        vid++;
        sb.push_back(mk(ev, ed, es, eb, ef, ee));
        #1;
    endtask

    task automatic drain;
        int budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() > 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 vid++; compare(mk(1'b0, NOP, 0, 0, 0, 1'b0));
        @(posedge clk); #1;
        vid++; compare(mk(1'b0, NOP, 0, 0, 0, 1'b0));
        rst = 1'b0;

        //   stall fl cl iv data           ev    exp data       s  b  f  e
        vec(RUN,  0, 0, 1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 0, 0, 0, 1'b0);
        vec(IGN,  0, 0, 1, 32'h12345678, 1'b1, 32'h12345678, 0, 0, 0, 1'b0);
        vec(RUN,  0, 0, 0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 0, 0, 0, 1'b0);
        vec(RUN,  0, 0, 1, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++)
            vec(HOLD, 0, 0, 1, 32'h11111111, 1'b1, 32'hA5A5A5A5, i + 1, 0, 0, 1'b0);
        vec(BUB,  0, 0, 1, 32'h22222222, 1'b0, NOP,          3, 1, 0, 1'b0);
        vec(RUN,  0, 0, 1, 32'h33333333, 1'b1, 32'h33333333, 3, 1, 0, 1'b0);
        vec(HOLD, 1, 0, 1, 32'h44444444, 1'b0, NOP,          3, 1, 1, 1'b0);
        vec(RUN,  1, 0, 1, 32'h55555555, 1'b0, NOP,          3, 1, 2, 1'b0);
        vec(RUN,  0, 0, 1, 32'h66666666, 1'b1, 32'h66666666, 3, 1, 2, 1'b0);
        vec(ILL,  0, 0, 1, 32'h77777777, 1'b1, 32'h66666666, 4, 1, 2, 1'b1);
        vec(RUN,  0, 1, 1, 32'h88888888, 1'b1, 32'h88888888, 0, 0, 0, 1'b1);
        vec(BUB,  0, 1, 1, 32'h88888888, 1'b0, NOP,          0, 0, 0, 1'b1);
        for (int i = 0; i < 20; i++)
            vec(HOLD, 0, 0, 1, 32'h99999999, 1'b0, NOP, (i + 1 > 15) ? 15 : i + 1, 0, 0, 1'b1);
        vec(RUN,  0, 0, 1, 32'hABCDEF01, 1'b1, 32'hABCDEF01, 15, 0, 0, 1'b1);
        vec(HOLD, 0, 0, 1, 32'hABCDEF02, 1'b1, 32'hABCDEF01, 15, 0, 0, 1'b1);
        drain();

        rst = 1'b1;
        #1 vid++; compare(mk(1'b0, NOP, 0, 0, 0, 1'b0));
        #1 rst = 1'b0;
        vec(RUN,  0, 0, 1, 32'h0BADC0DE, 1'b1, 32'h0BADC0DE, 0, 0, 0, 1'b0);
        vec(HOLD, 1, 1, 1, 32'h0BADC0DF, 1'b0, NOP,          0, 0, 0, 1'b0);
        vec(BUB,  1, 0, 1, 32'h0BADC0E0, 1'b0, NOP,          0, 0, 1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no completion, want finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
